// File: rtl/gnn_neighbor_aggregator.sv
// -----------------------------------------------------------------------------
// gnn_neighbor_aggregator
//
// Sequencing stage for the GNN datapath. For every destination node it scans
// one adjacency row, one source per cycle. It issues a feature-memory read for
// each neighbour and sums the returned feature vectors lane-wise. Each node's
// sum is then handed to the combine/update stage.
//
// Optional build macro:
//   GNN_AGG_SELF_LOOP_EN - a node's own feature is always read during its
//                          scan, whether or not its diagonal adjacency bit is
//                          set. It is never read twice.
//
// Ports:
//   clk          in   clock
//   reset        in   asynchronous, active-high reset
//   start        in   one-cycle pulse; starts a full-graph pass (IDLE only)
//   busy         out  FSM is not in IDLE
//   done         out  one-cycle pulse after the last node's output handshake
//   adj_row_addr out  adjacency row index (current destination node)
//   adj_row_in   in   adjacency row for adj_row_addr (combinational read)
//   feat_addr    out  feature memory source index
//   feat_rd_en   out  feature read strobe
//   feat_data    in   feature vector, valid one cycle after feat_rd_en
//   out_valid    out  aggregated result valid
//   out_ready    in   downstream accept
//   out_node     out  destination node of out_data
//   out_data     out  lane-wise neighbour sum, lane 0 in the LSBs
//
// Output handshake: a result transfers on any cycle where out_valid and
// out_ready are both high. While out_valid is high and out_ready is low,
// out_node and out_data hold their values. The result is never withdrawn.
// out_ready is ignored whenever out_valid is low.
// -----------------------------------------------------------------------------
module gnn_neighbor_aggregator #(
    parameter int NUM_NODES = 4,
    parameter int NUM_FEAT  = 3,
    parameter int FEAT_W    = 8,
    parameter int ACC_W     = FEAT_W + $clog2(NUM_NODES + 1),
    localparam int IDX_W    = $clog2(NUM_NODES)
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        start,
    output logic                        busy,
    output logic                        done,
    output logic [IDX_W-1:0]            adj_row_addr,
    input  logic [NUM_NODES-1:0]        adj_row_in,
    output logic [IDX_W-1:0]            feat_addr,
    output logic                        feat_rd_en,
    input  logic [NUM_FEAT*FEAT_W-1:0]  feat_data,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [IDX_W-1:0]            out_node,
    output logic [NUM_FEAT*ACC_W-1:0]   out_data
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_NODES - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SCAN  = 2'd1,
        S_DRAIN = 2'd2,
        S_OUT   = 2'd3
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [IDX_W-1:0]   node;
    logic [IDX_W-1:0]   src;
    logic               rd_pend;
    logic               done_q;
    logic [ACC_W-1:0]   acc [NUM_FEAT];

    // Decoded control from the next-state logic.
    logic               rd_sel;      // read the current source this cycle
    logic               clear_acc;   // a new node scan starts next cycle
    logic               node_hs;     // output handshake this cycle
    logic               pass_end;    // handshake of the last node

    // ---------------------------------------------------------------------
    // FSM state register
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // ---------------------------------------------------------------------
    // FSM next-state and control decode
    // ---------------------------------------------------------------------
    always_comb begin
        state_next = state;
        rd_sel     = 1'b0;
        clear_acc  = 1'b0;
        node_hs    = 1'b0;
        pass_end   = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_next = S_SCAN;
                    clear_acc  = 1'b1;
                end
            end
            S_SCAN: begin
`ifdef GNN_AGG_SELF_LOOP_EN
                // OR-ing in the diagonal means a set diagonal bit still
                // produces exactly one read.
                rd_sel = adj_row_in[src] | (src == node);
`else
                rd_sel = adj_row_in[src];
`endif
                if (src == LAST_IDX) begin
                    state_next = S_DRAIN;
                end
            end
            S_DRAIN: begin
                // The read issued for the last source is absorbed here.
                state_next = S_OUT;
            end
            S_OUT: begin
                if (out_ready) begin
                    node_hs = 1'b1;
                    if (node == LAST_IDX) begin
                        state_next = S_IDLE;
                        pass_end   = 1'b1;
                    end else begin
                        state_next = S_SCAN;
                        clear_acc  = 1'b1;
                    end
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // ---------------------------------------------------------------------
    // Index counters, read pipeline and accumulators
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            node    <= '0;
            src     <= '0;
            rd_pend <= 1'b0;
            done_q  <= 1'b0;
            for (int k = 0; k < NUM_FEAT; k++) begin
                acc[k] <= '0;
            end
        end else begin
            // feat_data returns one cycle after the strobe, so a registered
            // copy of the strobe marks the cycle in which to add it.
            rd_pend <= rd_sel;
            done_q  <= pass_end;

            if (state == S_IDLE && start) begin
                node <= '0;
            end else if (node_hs) begin
                node <= (node == LAST_IDX) ? '0 : node + 1'b1;
            end

            if (clear_acc) begin
                src <= '0;
            end else if (state == S_SCAN) begin
                src <= (src == LAST_IDX) ? '0 : src + 1'b1;
            end

            // rd_pend is always low when clear_acc fires (IDLE or OUT), so
            // giving clear priority cannot drop a returned feature.
            for (int k = 0; k < NUM_FEAT; k++) begin
                if (clear_acc) begin
                    acc[k] <= '0;
                end else if (rd_pend) begin
                    acc[k] <= acc[k] + ACC_W'(feat_data[k*FEAT_W +: FEAT_W]);
                end
            end
        end
    end

    // ---------------------------------------------------------------------
    // Outputs
    // ---------------------------------------------------------------------
    always_comb begin
        out_data = '0;
        for (int k = 0; k < NUM_FEAT; k++) begin
            out_data[k*ACC_W +: ACC_W] = acc[k];
        end
    end

    assign busy         = (state != S_IDLE);
    assign done         = done_q;
    assign adj_row_addr = node;
    assign feat_addr    = src;
    assign feat_rd_en   = rd_sel;
    assign out_valid    = (state == S_OUT);
    assign out_node     = node;

endmodule
